// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch into a DEPTH-entry
// PC/instruction queue feeding decode, with redirect flush and in-flight response drop.
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [XLEN-1:0]        id_pc,
  output logic [31:0]            id_instr,
  output logic [$clog2(DEPTH):0] outstanding
);
  localparam int              PW         = $clog2(DEPTH);
  localparam int              CW         = PW + 1;
  localparam logic [CW:0]     DEPTH_S    = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
  localparam logic [31:0]     NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   drop_cnt;
  logic [PW-1:0]   q_head;
  logic [PW-1:0]   q_tail;
  logic [PW-1:0]   pend_head;
  logic [PW-1:0]   pend_tail;
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [31:0]     q_instr [DEPTH];
  logic [XLEN-1:0] pend_pc [DEPTH];
  logic [CW:0]     credit_used;
  logic [CW:0]     fifo_used;
  logic            issue;
  logic            live_rsp;
  logic            drop_rsp;
  logic            pop;

  // Queue slots are reserved at issue time, so a live response always has room.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign fifo_used      = {1'b0, drop_cnt} + {1'b0, outstanding};
  assign imem_req_valid = !reset && !redirect_valid &&
                          (credit_used < DEPTH_S) && (fifo_used < DEPTH_S);
  assign imem_addr      = fetch_pc;
  assign issue          = imem_req_valid && imem_req_ready;
  assign live_rsp       = imem_rvalid && (drop_cnt == '0);
  assign drop_rsp       = imem_rvalid && (drop_cnt != '0);
  assign id_valid       = (count != '0);
  assign pop            = id_valid && id_ready;
  assign id_pc          = id_valid ? q_pc[q_head]    : '0;
  assign id_instr       = id_valid ? q_instr[q_head] : NOP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      pend_head   <= '0;
      pend_tail   <= '0;
    end else begin
      if (imem_rvalid) pend_head <= pend_head + PW'(1);
      if (issue) begin
        pend_tail <= pend_tail + PW'(1);
        fetch_pc  <= fetch_pc + XLEN'(4);
      end
      if (redirect_valid) begin
        // Every request still in flight, minus the one answered this cycle, must be drained.
        fetch_pc    <= redirect_pc & ALIGN_MASK;
        count       <= '0;
        q_head      <= '0;
        q_tail      <= '0;
        outstanding <= '0;
        drop_cnt    <= drop_cnt + outstanding - CW'(imem_rvalid);
      end else begin
        if (live_rsp) q_tail <= q_tail + PW'(1);
        if (pop)      q_head <= q_head + PW'(1);
        count       <= count + CW'(live_rsp) - CW'(pop);
        outstanding <= outstanding + CW'(issue) - CW'(live_rsp);
        drop_cnt    <= drop_cnt - CW'(drop_rsp);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pend_pc[pend_tail] <= fetch_pc;
    if (live_rsp && !redirect_valid) begin
      q_pc[q_tail]    <= pend_pc[pend_head];
      q_instr[q_tail] <= imem_rdata;
    end
  end

  assert property (@(posedge clk) disable iff (reset) imem_rvalid |-> (fifo_used != '0));
  assert property (@(posedge clk) disable iff (reset) live_rsp |-> (count != DEPTH_C));

endmodule
